fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Generates the per-cycle fetch control (noOp / newPcValid / newPc) that steers the PC register of the fetch stage.
- Sequences boot:
  - waits a fixed number of cycles after reset;
  - issues the reset vector.
- Arbitrates between simultaneous redirect and stall requests (trap > branch > stall).
- Tracks the one-cycle instruction-RAM latency so downstream decode only accepts instructions fetched on the architecturally correct path.

Parameters:
- cXLEN, 32, data/address width.
- cResetVec, 32'h0000_0000, first PC after boot; must be 4-byte aligned.
- cBootWait, 2, idle cycles after reset release before the reset vector is issued; legal range 0..15.

Ports:
- iClk  input  1  core clock.
- iRst  input  1  synchronous, active-high reset.
- iStall  input  1  level; decode hazard, hold the PC.
- iBranchValid  input  1  pulse; taken branch/jump from execute.
- iBranchTarget  input  cXLEN  branch target, valid with iBranchValid.
- iTrapValid  input  1  pulse; exception/interrupt redirect.
- iTrapVec  input  cXLEN  trap handler address.
- oNoOp  output  1  maps to tFetchCtrl.noOp.
- oNewPcValid  output  1  maps to tFetchCtrl.newPcValid.
- oNewPc  output  cXLEN  maps to tFetchCtrl.newPc.
- oInstrValid  output  1  fetch-stage instruction output is on-path and may be decoded.
- oMisalign  output  1  one-cycle pulse on a misaligned branch target.
- oState  output  2  current state encoding: BOOT=0, RUN=1, FLUSH=2.

Behaviour:

Timing model:
- State, boot counter and oInstrValid are registered.
- oNoOp, oNewPcValid, oNewPc and oMisalign are combinational from state and inputs, so a redirect takes effect on the PC at the next posedge (zero added latency).

Reset (iRst=1 at a posedge):
- state := BOOT; bootCnt := cBootWait; oInstrValid := 0.
- While iRst is high, outputs are forced: oNoOp=1, oNewPcValid=0, oNewPc=0, oMisalign=0.
- Reset asserted in any state aborts that state and any pending redirect.

BOOT:
- While bootCnt != 0: oNoOp=1; bootCnt decrements; all branch, trap and stall inputs are ignored.
- When bootCnt == 0: oNewPcValid=1, oNewPc=cResetVec, oNoOp=0; next state is FLUSH.
- With cBootWait=0, the first cycle after reset release issues the vector.

Redirect arbitration (identical in RUN and FLUSH; priority trap > branch > stall):
- Trap: oNewPcValid=1, oNewPc=iTrapVec; next state is FLUSH.
- Branch, with iBranchTarget[1:0]==0: oNewPcValid=1, oNewPc=iBranchTarget; next state is FLUSH.
- Branch, with iBranchTarget[1:0]!=0: oMisalign=1, oNewPcValid=1, oNewPc=iTrapVec; next state is FLUSH.
- Stall (no trap or branch): oNoOp=1, oNewPcValid=0; state is unchanged; oInstrValid holds its value.
- No request: oNoOp=0, oNewPcValid=0 (PC += 4).
- A redirect in the same cycle as iStall wins; that stall cycle is consumed.
- oNewPc=0 whenever oNewPcValid=0.

oInstrValid update:
- Cleared on the cycle after any redirect.
- Set on the cycle after a non-stalled, non-redirect cycle in RUN or FLUSH.
- Always 0 in BOOT.

FLUSH:
- One bubble cycle: the RAM output reflects the pre-redirect address, so oInstrValid=0 during FLUSH.
- If not stalled and not redirected: next state is RUN.
- Stall in FLUSH holds FLUSH.

Boundaries:
- Back-to-back redirects on consecutive cycles: each is honored; oInstrValid stays 0 until one clean cycle passes.
- No PC arithmetic is performed in this block; wrap-around of PC+4 is owned by fetch.

Test Plan:
- cBootWait=2, cResetVec=32'h100, release iRst → oNoOp=1 for 2 cycles, then oNewPcValid=1/oNewPc=32'h100 for 1 cycle, oState BOOT→FLUSH→RUN, oInstrValid first 1 two cycles after the vector.
- RUN, iBranchValid=1 with iBranchTarget=32'h240 → same-cycle oNewPcValid=1, oNewPc=32'h240; next cycle oInstrValid=0, oState=FLUSH; following cycle RUN with oInstrValid=1.
- Same cycle iTrapValid=1 (iTrapVec=32'h80), iBranchValid=1 (32'h240), iStall=1 → oNewPc=32'h80, oNoOp=0, oMisalign=0.
- iBranchTarget=32'h242 → oMisalign=1 for one cycle, oNewPc=iTrapVec, FLUSH entered.
- iStall held 3 cycles in RUN with oInstrValid=1 → oNoOp=1 for 3 cycles, oInstrValid stays 1, state stays RUN; stall in FLUSH holds FLUSH with oInstrValid=0.
- iRst asserted during FLUSH and during BOOT count, with iBranchValid=1 → next cycle oState=BOOT, bootCnt reloads to cBootWait, no oNewPcValid until the count expires again.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC steering: boot delay, reset-vector issue, and trap > branch > stall
// arbitration, plus tracking of which RAM outputs lie on the correct path.
module fetch_sequencer #(
  parameter int              cXLEN     = 32,
  parameter logic [cXLEN-1:0] cResetVec = '0,
  parameter int              cBootWait = 2
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStall,
  input  logic             iBranchValid,
  input  logic [cXLEN-1:0] iBranchTarget,
  input  logic             iTrapValid,
  input  logic [cXLEN-1:0] iTrapVec,
  output logic             oNoOp,
  output logic             oNewPcValid,
  output logic [cXLEN-1:0] oNewPc,
  output logic             oInstrValid,
  output logic             oMisalign,
  output logic [1:0]       oState
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] cBootInit = 4'(cBootWait);

  state_t           r_state;
  logic [3:0]       r_boot_cnt;
  logic             r_instr_valid;

  state_t           w_next_state;
  logic [3:0]       w_next_cnt;
  logic             w_next_iv;
  logic             w_no_op;
  logic             w_new_pc_valid;
  logic [cXLEN-1:0] w_new_pc;
  logic             w_misalign;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = r_boot_cnt;
    w_next_iv      = r_instr_valid;
    w_no_op        = 1'b0;
    w_new_pc_valid = 1'b0;
    w_new_pc       = '0;
    w_misalign     = 1'b0;

    if (iRst) begin
      w_no_op = 1'b1;
    end else begin
      case (r_state)
        ST_RUN, ST_FLUSH: begin
          if (iTrapValid) begin
            w_new_pc_valid = 1'b1;
            w_new_pc       = iTrapVec;
          end else if (iBranchValid) begin
            w_new_pc_valid = 1'b1;
            // A misaligned target is turned into a trap redirect in the same cycle.
            if (iBranchTarget[1:0] != 2'b00) begin
              w_misalign = 1'b1;
              w_new_pc   = iTrapVec;
            end else begin
              w_new_pc   = iBranchTarget;
            end
          end

          if (iTrapValid || iBranchValid) begin
            w_next_state = ST_FLUSH;
            w_next_iv    = 1'b0;
          end else if (iStall) begin
            w_no_op = 1'b1;
          end else begin
            w_next_state = ST_RUN;
            w_next_iv    = 1'b1;
          end
        end

        default: begin
          w_next_iv = 1'b0;
          if (r_boot_cnt != 4'd0) begin
            w_no_op    = 1'b1;
            w_next_cnt = r_boot_cnt - 4'd1;
          end else begin
            w_new_pc_valid = 1'b1;
            w_new_pc       = cResetVec;
            w_next_state   = ST_FLUSH;
          end
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state       <= ST_BOOT;
      r_boot_cnt    <= cBootInit;
      r_instr_valid <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_boot_cnt    <= w_next_cnt;
      r_instr_valid <= w_next_iv;
    end
  end

  assign oNoOp       = w_no_op;
  assign oNewPcValid = w_new_pc_valid;
  assign oNewPc      = w_new_pc;
  assign oMisalign   = w_misalign;
  assign oInstrValid = r_instr_valid;
  assign oState      = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: each stimulus cycle pushes its expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_VEC = 32'h0000_0100;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        trap_valid;
  logic [31:0] trap_vec;
  logic        no_op;
  logic        new_pc_valid;
  logic [31:0] new_pc;
  logic        instr_valid;
  logic        misalign;
  logic [1:0]  state;

  typedef struct {
    bit          chk_regs;
    logic [1:0]  st;
    logic        iv;
    logic        no_op;
    logic        npv;
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  fetch_sequencer #(
    .cXLEN    (32),
    .cResetVec(RESET_VEC),
    .cBootWait(2)
  ) dut (
    .iClk         (clk),
    .iRst         (rst),
    .iStall       (stall),
    .iBranchValid (br_valid),
    .iBranchTarget(br_target),
    .iTrapValid   (trap_valid),
    .iTrapVec     (trap_vec),
    .oNoOp        (no_op),
    .oNewPcValid  (new_pc_valid),
    .oNewPc       (new_pc),
    .oInstrValid  (instr_valid),
    .oMisalign    (misalign),
    .oState       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Drive one cycle of inputs just after the posedge and record what that cycle must show.
  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] tgt,
                      input bit t, input logic [31:0] tv, input bit chk,
                      input logic [1:0] e_st, input bit e_iv, input bit e_noop,
                      input bit e_npv, input logic [31:0] e_pc, input bit e_mis);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = r;
    stall      = s;
    br_valid   = b;
    br_target  = tgt;
    trap_valid = t;
    trap_vec   = tv;
    e.chk_regs = chk;
    e.st       = e_st;
    e.iv       = e_iv;
    e.no_op    = e_noop;
    e.npv      = e_npv;
    e.pc       = e_pc;
    e.mis      = e_mis;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk_regs) begin
        check("state", 32'(state), 32'(e.st));
        check("instr_valid", 32'(instr_valid), 32'(e.iv));
      end
      check("no_op", 32'(no_op), 32'(e.no_op));
      check("new_pc_valid", 32'(new_pc_valid), 32'(e.npv));
      check("new_pc", new_pc, e.pc);
      check("misalign", 32'(misalign), 32'(e.mis));
    end
  end

  initial begin
    int waited;
    rst = 1'b1; stall = 1'b0; br_valid = 1'b0; br_target = '0;
    trap_valid = 1'b0; trap_vec = '0;

    //    rst s b tgt           t tv            chk st       iv noop npv pc           mis
    // Reset forces outputs even with a branch present.
    step(1, 0, 1, 32'h240,     0, 32'h0,       0, S_BOOT,  0, 1, 0, 32'h0,       0);
    step(1, 0, 0, 32'h0,       0, 32'h0,       1, S_BOOT,  0, 1, 0, 32'h0,       0);
    // Boot count: requests ignored, two no-op cycles, then the reset vector.
    step(0, 0, 1, 32'h240,     1, 32'h80,      1, S_BOOT,  0, 1, 0, 32'h0,       0);
    step(0, 1, 0, 32'h0,       0, 32'h0,       1, S_BOOT,  0, 1, 0, 32'h0,       0);
    step(0, 0, 0, 32'h0,       0, 32'h0,       1, S_BOOT,  0, 0, 1, RESET_VEC,   0);
    step(0, 0, 0, 32'h0,       0, 32'h0,       1, S_FLUSH, 0, 0, 0, 32'h0,       0);
    step(0, 0, 0, 32'h0,       0, 32'h0,       1, S_RUN,   1, 0, 0, 32'h0,       0);
    // Aligned branch, bubble, then valid again.
    step(0, 0, 1, 32'h240,     0, 32'h0,       1, S_RUN,   1, 0, 1, 32'h240,     0);
    step(0, 0, 0, 32'h0,       0, 32'h0,       1, S_FLUSH, 0, 0, 0, 32'h0,       0);
    // Trap beats branch and stall.
    step(0, 1, 1, 32'h240,     1, 32'h80,      1, S_RUN,   1, 0, 1, 32'h80,      0);
    // Misaligned branch during FLUSH redirects to the trap vector.
    step(0, 0, 1, 32'h242,     0, 32'h300,     1, S_FLUSH, 0, 0, 1, 32'h300,     1);
    // Back-to-back redirect.
    step(0, 0, 1, 32'h400,     0, 32'h300,     1, S_FLUSH, 0, 0, 1, 32'h400,     0);
    // Stall in FLUSH holds FLUSH with instr_valid low.
    step(0, 1, 0, 32'h0,       0, 32'h0,       1, S_FLUSH, 0, 1, 0, 32'h0,       0);
    step(0, 1, 0, 32'h0,       0, 32'h0,       1, S_FLUSH, 0, 1, 0, 32'h0,       0);
    step(0, 0, 0, 32'h0,       0, 32'h0,       1, S_FLUSH, 0, 0, 0, 32'h0,       0);
    step(0, 0, 0, 32'h0,       0, 32'h0,       1, S_RUN,   1, 0, 0, 32'h0,       0);
    // Three stall cycles in RUN keep instr_valid and the state.
    step(0, 1, 0, 32'h0,       0, 32'h0,       1, S_RUN,   1, 1, 0, 32'h0,       0);
    step(0, 1, 0, 32'h0,       0, 32'h0,       1, S_RUN,   1, 1, 0, 32'h0,       0);
    step(0, 1, 0, 32'h0,       0, 32'h0,       1, S_RUN,   1, 1, 0, 32'h0,       0);
    step(0, 0, 0, 32'h0,       0, 32'h0,       1, S_RUN,   1, 0, 0, 32'h0,       0);
    step(0, 0, 1, 32'h500,     0, 32'h0,       1, S_RUN,   1, 0, 1, 32'h500,     0);
    // Reset during FLUSH with a branch pending aborts it and restarts the boot count.
    step(1, 0, 1, 32'h600,     0, 32'h0,       1, S_FLUSH, 0, 1, 0, 32'h0,       0);
    step(0, 0, 1, 32'h600,     0, 32'h0,       1, S_BOOT,  0, 1, 0, 32'h0,       0);
    step(0, 0, 1, 32'h600,     0, 32'h0,       1, S_BOOT,  0, 1, 0, 32'h0,       0);
    step(0, 0, 0, 32'h0,       0, 32'h0,       1, S_BOOT,  0, 0, 1, RESET_VEC,   0);
    step(0, 0, 0, 32'h0,       0, 32'h0,       1, S_FLUSH, 0, 0, 0, 32'h0,       0);
    step(0, 0, 0, 32'h0,       0, 32'h0,       1, S_RUN,   1, 0, 0, 32'h0,       0);
    // Reset in RUN, then again mid boot count: the count reloads to its full value.
    step(1, 0, 0, 32'h0,       0, 32'h0,       1, S_RUN,   1, 1, 0, 32'h0,       0);
    step(0, 0, 0, 32'h0,       0, 32'h0,       1, S_BOOT,  0, 1, 0, 32'h0,       0);
    step(1, 0, 1, 32'h700,     0, 32'h0,       1, S_BOOT,  0, 1, 0, 32'h0,       0);
    step(0, 0, 1, 32'h700,     0, 32'h0,       1, S_BOOT,  0, 1, 0, 32'h0,       0);
    step(0, 0, 1, 32'h700,     0, 32'h0,       1, S_BOOT,  0, 1, 0, 32'h0,       0);
    step(0, 0, 0, 32'h0,       0, 32'h0,       1, S_BOOT,  0, 0, 1, RESET_VEC,   0);
    step(0, 0, 0, 32'h0,       0, 32'h0,       1, S_FLUSH, 0, 0, 0, 32'h0,       0);
    step(0, 0, 0, 32'h0,       0, 32'h0,       1, S_RUN,   1, 0, 0, 32'h0,       0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
